iq_stream_grabber: RTL and testbench
====================================

IQ_STREAM_GRABBER -- requirements
Module: iq_stream_grabber

Interface
REQ-001 SHALL have parameter DW, default 21: width of each signed I or Q word.
REQ-002 SHALL have parameter N_CH, default 4, range 1..16: number of IQ channels per frame.
REQ-003 SHALL have parameter DEC_W, default 8: width of the decimation period input.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port stream_in, input, DW bits, signed: serialized word stream.
REQ-007 SHALL have port strobe_in, input, 1 bit: stream_in valid in this cycle.
REQ-008 SHALL have port freeze, input, 1 bit: suppresses publication of new frames.
REQ-009 SHALL have port dec_period, input, DEC_W bits: publish one of every dec_period+1 completed frames.
REQ-010 SHALL have port iq_out, output, 2*N_CH*DW bits: channel k I at bits [(2k+1)*DW-1 : 2k*DW], Q at bits [(2k+2)*DW-1 : (2k+1)*DW].
REQ-011 SHALL have port strobe_out, output, 1 bit: one-cycle pulse when iq_out updates.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted frame.
REQ-013 SHALL have port frame_cnt, output, 16 bits: count of published frames.

Function
REQ-014 SHALL define a frame as 2*N_CH consecutive strobe_in=1 cycles carrying the order I0,Q0,I1,Q1,...,I(N-1),Q(N-1).
REQ-015 SHALL keep word index idx (0..2N_CH-1); each strobe_in=1 cycle SHALL store stream_in into shadow slot idx and increment idx.
REQ-016 SHALL, when strobe_in=1 and idx=2N_CH-1, complete the frame and reset idx to 0 on the same edge.
REQ-017 SHALL treat continued strobe_in=1 after completion as word 0 of the next frame; back-to-back frames SHALL be lossless.
REQ-018 SHALL, when strobe_in=0 and idx!=0, abort the frame: idx->0, frame_err=1 for exactly the next cycle, partial shadow not published, dec_cnt unchanged.
REQ-019 SHALL ignore strobe_in=0 with idx=0.
REQ-020 SHALL keep decimation counter dec_cnt (DEC_W bits): on each completed frame, if dec_cnt>=dec_period then dec_cnt->0 and the frame is eligible; else dec_cnt+1 and the frame is not eligible.
REQ-021 SHALL treat dec_period=0 as publish-every-frame; a dec_period change takes effect at the next completion.
REQ-022 SHALL, for an eligible frame with freeze=0 on the completion cycle, update iq_out with all 2N_CH words (last word taken directly from stream_in) and assert strobe_out on the cycle following the last word (latency 1).
REQ-023 SHALL, for an eligible frame with freeze=1, not publish and not pulse strobe_out; dec_cnt SHALL still advance.
REQ-024 SHALL hold iq_out stable between publications.
REQ-025 SHALL increment frame_cnt together with each strobe_out pulse, wrapping 0xFFFF->0x0000.
REQ-026 SHALL never assert strobe_out and frame_err in the same cycle.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear idx, dec_cnt, shadow, iq_out, strobe_out, frame_err and frame_cnt to 0.
REQ-028 SHALL discard any partial frame on rst, without a frame_err pulse; the first strobe_in=1 after release is word 0.

Verification
REQ-029 SHALL test, with N_CH=4, DW=21, dec_period=0: 8 strobed words 1..8 -> one cycle after word 8, strobe_out=1, I0=1,Q0=2,...,Q3=8, frame_cnt=1.
REQ-030 SHALL test 24 back-to-back strobed words 1..24 -> three strobe_out pulses 8 cycles apart; final iq_out holds 17..24; frame_cnt=3.
REQ-031 SHALL test strobe_in dropping after 5 words, then a full frame of 100..107 -> frame_err pulse once, then iq_out holds 100..107; no strobe_out for the aborted frame.
REQ-032 SHALL test dec_period=2 over 9 complete frames -> strobe_out only on frames 3, 6 and 9.
REQ-033 SHALL test freeze=1 across 2 frames, then freeze=0 -> no strobe_out while frozen; iq_out unchanged; the next frame publishes.
REQ-034 SHALL test rst asserted mid-frame and frame_cnt at 0xFFFF -> all outputs 0 immediately; separately, wrap 0xFFFF->0x0000 on the next publication.

Source files
------------

// File: rtl/iq_stream_grabber.sv
// Deserializes a strobed I/Q word stream into a frame-wide shadow and publishes
// whole frames, with decimation, freeze and an abort flag for broken frames.
module iq_stream_grabber #(
  parameter int DW    = 21,
  parameter int N_CH  = 4,
  parameter int DEC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DW-1:0]     stream_in,
  input  logic                     strobe_in,
  input  logic                     freeze,
  input  logic [DEC_W-1:0]         dec_period,
  output logic [2*N_CH*DW-1:0]     iq_out,
  output logic                     strobe_out,
  output logic                     frame_err,
  output logic [15:0]              frame_cnt
);

  localparam int NW = 2 * N_CH;
  localparam int IW = (NW > 2) ? $clog2(NW) : 1;

  logic [IW-1:0]       idx_q, idx_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic [DW-1:0]       shadow_q [NW-1];
  logic [DW-1:0]       shadow_d [NW-1];
  logic [NW*DW-1:0]    iq_q, iq_d;
  logic                sout_q, sout_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                last_word;

  assign last_word = (idx_q == IW'(NW - 1));

  always_comb begin
    idx_d    = idx_q;
    dec_d    = dec_q;
    shadow_d = shadow_q;
    iq_d     = iq_q;
    sout_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    if (strobe_in) begin
      if (last_word) begin
        idx_d = '0;
        if (dec_q >= dec_period) begin
          dec_d = '0;
          if (!freeze) begin
            // The final word bypasses the shadow so publication has latency 1.
            for (int k = 0; k < NW - 1; k++) begin
              iq_d[k*DW +: DW] = shadow_q[k];
            end
            iq_d[(NW-1)*DW +: DW] = stream_in;
            sout_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
          end
        end else begin
          dec_d = dec_q + DEC_W'(1);
        end
      end else begin
        for (int k = 0; k < NW - 1; k++) begin
          if (idx_q == IW'(k)) shadow_d[k] = stream_in;
        end
        idx_d = idx_q + IW'(1);
      end
    end else if (idx_q != '0) begin
      idx_d = '0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      dec_q  <= '0;
      iq_q   <= '0;
      sout_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      for (int k = 0; k < NW - 1; k++) shadow_q[k] <= '0;
    end else begin
      idx_q    <= idx_d;
      dec_q    <= dec_d;
      iq_q     <= iq_d;
      sout_q   <= sout_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  logic [15:0] frame_cnt_q;
  assign frame_cnt_q = cnt_q;

  assign iq_out     = iq_q;
  assign strobe_out = sout_q;
  assign frame_err  = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_iq_stream_grabber.sv
// Bench for iq_stream_grabber: directed scenarios plus random traffic, all
// compared cycle by cycle against a frame-level queue model.
module tb_iq_stream_grabber;

  localparam int DW    = 21;
  localparam int N_CH  = 4;
  localparam int DEC_W = 8;
  localparam int NW    = 2 * N_CH;
  localparam int VW    = NW * DW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [DW-1:0]  stream_in;
  logic                  strobe_in;
  logic                  freeze;
  logic [DEC_W-1:0]      dec_period;
  logic [VW-1:0]         iq_out;
  logic                  strobe_out;
  logic                  frame_err;
  logic [15:0]           frame_cnt;

  iq_stream_grabber #(.DW(DW), .N_CH(N_CH), .DEC_W(DEC_W)) dut (
    .clk(clk), .rst(rst), .stream_in(stream_in), .strobe_in(strobe_in),
    .freeze(freeze), .dec_period(dec_period), .iq_out(iq_out),
    .strobe_out(strobe_out), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  logic [DW-1:0] part [$];
  logic [DW-1:0] m_iq [NW];
  int            m_dec;
  logic [15:0]   m_cnt;
  logic          exp_sout, exp_err;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    for (int k = 0; k < NW; k++) m_iq[k] = '0;
    m_dec = 0;
    m_cnt = '0;
    exp_sout = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [VW-1:0] e;
    for (int k = 0; k < NW; k++) e[k*DW +: DW] = m_iq[k];
    chk({tag, ".strobe_out"}, VW'(strobe_out), VW'(exp_sout));
    chk({tag, ".frame_err"}, VW'(frame_err), VW'(exp_err));
    chk({tag, ".frame_cnt"}, VW'(frame_cnt), VW'(m_cnt));
    chk({tag, ".iq_out"}, iq_out, e);
  endtask

  // Called at a falling edge: drives one cycle, predicts the result, checks it.
  task automatic step(input string tag, input logic s, input logic [DW-1:0] d, input logic fz);
    strobe_in = s;
    stream_in = d;
    freeze    = fz;
    exp_sout  = 1'b0;
    exp_err   = 1'b0;
    if (s) begin
      part.push_back(d);
      if (part.size() == NW) begin
        if (m_dec >= int'(dec_period)) begin
          m_dec = 0;
          if (!fz) begin
            for (int k = 0; k < NW; k++) m_iq[k] = part[k];
            exp_sout = 1'b1;
            m_cnt = m_cnt + 16'd1;
          end
        end else begin
          m_dec = m_dec + 1;
        end
        part.delete();
      end
    end else if (part.size() != 0) begin
      part.delete();
      exp_err = 1'b1;
    end
    @(negedge clk);
    if (strobe_out) pulses++;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    strobe_in = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preset_cnt();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
  endtask

  initial begin
    rst = 1'b1; strobe_in = 1'b0; stream_in = '0; freeze = 1'b0; dec_period = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // single frame 1..8
    for (int i = 1; i <= 8; i++) step("one_frame", 1'b1, DW'(i), 1'b0);
    chk("one_frame.I0", VW'(iq_out[DW-1:0]), VW'(1));
    chk("one_frame.Q3", VW'(iq_out[VW-1 -: DW]), VW'(8));
    chk("one_frame.cnt", VW'(frame_cnt), VW'(1));
    step("idle", 1'b0, '0, 1'b0);

    // three back-to-back frames 1..24
    pulses = 0;
    for (int i = 1; i <= 24; i++) step("b2b", 1'b1, DW'(i), 1'b0);
    step("b2b_idle", 1'b0, '0, 1'b0);
    chk("b2b.pulses", VW'(pulses), VW'(3));
    chk("b2b.I0", VW'(iq_out[DW-1:0]), VW'(17));
    chk("b2b.cnt", VW'(frame_cnt), VW'(4));

    // aborted frame then 100..107
    pulses = 0;
    for (int i = 1; i <= 5; i++) step("abort", 1'b1, DW'(50 + i), 1'b0);
    step("abort_drop", 1'b0, '0, 1'b0);
    chk("abort.err", VW'(frame_err), VW'(1));
    for (int i = 100; i <= 107; i++) step("after_abort", 1'b1, DW'(i), 1'b0);
    step("after_abort_idle", 1'b0, '0, 1'b0);
    chk("abort.pulses", VW'(pulses), VW'(1));
    chk("abort.Q3", VW'(iq_out[VW-1 -: DW]), VW'(107));

    // decimation by 3 over 9 frames
    dec_period = 8'd2;
    pulses = 0;
    for (int f = 0; f < 9; f++)
      for (int w = 0; w < NW; w++) step("dec", 1'b1, DW'($urandom), 1'b0);
    step("dec_idle", 1'b0, '0, 1'b0);
    chk("dec.pulses", VW'(pulses), VW'(3));
    dec_period = 8'd0;

    // freeze across two frames, then release
    pulses = 0;
    for (int f = 0; f < 2; f++)
      for (int w = 0; w < NW; w++) step("freeze", 1'b1, DW'($urandom), 1'b1);
    chk("freeze.pulses", VW'(pulses), VW'(0));
    for (int w = 0; w < NW; w++) step("unfreeze", 1'b1, DW'(200 + w), 1'b0);
    chk("unfreeze.pulses", VW'(pulses), VW'(1));
    chk("unfreeze.I0", VW'(iq_out[DW-1:0]), VW'(200));

    // reset mid-frame with frame_cnt at 0xFFFF
    preset_cnt();
    chk("preset.cnt", VW'(frame_cnt), VW'(16'hFFFF));
    for (int w = 0; w < 3; w++) step("pre_rst", 1'b1, DW'($urandom), 1'b0);
    do_reset("rst_mid");
    for (int w = 0; w < NW; w++) step("post_rst", 1'b1, DW'(300 + w), 1'b0);
    chk("post_rst.I0", VW'(iq_out[DW-1:0]), VW'(300));

    // wrap 0xFFFF -> 0
    preset_cnt();
    for (int w = 0; w < NW; w++) step("wrap", 1'b1, DW'($urandom), 1'b0);
    chk("wrap.cnt", VW'(frame_cnt), VW'(0));

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) dec_period = DEC_W'($urandom_range(0, 3));
      step("rand", ($urandom_range(0, 99) < 88), DW'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
